// File: rtl/game_sprite_control.sv
// Sprite position/velocity controller: frame-divided motion steps, on-screen tracking and raster hit test.
// Define GAME_SPRITE_WRAP_EN to wrap the sprite around the screen instead of freezing it at the edge.
module game_sprite_control #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int SPRITE_W   = 8,
    parameter int SPRITE_H   = 8,
    parameter int UPDATE_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_xy,
    input  logic       write_dxy,
    input  logic       enable_update,
    input  logic       frame_tick,
    input  logic [9:0] x0,
    input  logic [9:0] y0,
    input  logic [3:0] dx0,
    input  logic [3:0] dy0,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       within_screen,
    output logic       sprite_hit
);

    localparam logic [7:0]  DIV_LAST = 8'(UPDATE_DIV - 1);
    localparam logic [10:0] SPR_W11  = 11'(SPRITE_W);
    localparam logic [10:0] SPR_H11  = 11'(SPRITE_H);

    logic signed [11:0] pos_x, pos_y;
    logic signed [11:0] sum_x, sum_y;
    logic signed [11:0] next_x, next_y;
    logic        [3:0]  vel_x, vel_y;
    logic        [7:0]  div_cnt;
    logic               step;
    logic               next_within;
    logic               hit_now;

`ifdef GAME_SPRITE_WRAP_EN
    localparam logic signed [11:0] SCR_W12 = 12'(SCREEN_W);
    localparam logic signed [11:0] SCR_H12 = 12'(SCREEN_H);

    // A single correction suffices: one step moves at most 8 pixels.
    function automatic logic signed [11:0] wrap_coord(input logic signed [11:0] v,
                                                      input logic signed [11:0] lim);
        if (v[11])
            return v + lim;
        else if (v >= lim)
            return v - lim;
        else
            return v;
    endfunction
`else
    localparam logic signed [13:0] SCR_W14 = 14'(SCREEN_W);
    localparam logic signed [13:0] SCR_H14 = 14'(SCREEN_H);
    localparam logic signed [13:0] SPR_W14 = 14'(SPRITE_W);
    localparam logic signed [13:0] SPR_H14 = 14'(SPRITE_H);

    function automatic logic on_screen(input logic signed [11:0] px,
                                       input logic signed [11:0] py);
        logic signed [13:0] ex, ey;
        ex = {{2{px[11]}}, px};
        ey = {{2{py[11]}}, py};
        return !ex[13] && (ex + SPR_W14 <= SCR_W14) &&
               !ey[13] && (ey + SPR_H14 <= SCR_H14);
    endfunction
`endif

    assign x = pos_x[9:0];
    assign y = pos_y[9:0];

    assign step  = frame_tick && enable_update && (div_cnt == DIV_LAST) && within_screen;
    assign sum_x = pos_x + {{8{vel_x[3]}}, vel_x};
    assign sum_y = pos_y + {{8{vel_y[3]}}, vel_y};

    always_comb begin
        next_x = pos_x;
        next_y = pos_y;
        if (write_xy) begin
            next_x = {2'b00, x0};
            next_y = {2'b00, y0};
        end else if (step) begin
`ifdef GAME_SPRITE_WRAP_EN
            next_x = wrap_coord(sum_x, SCR_W12);
            next_y = wrap_coord(sum_y, SCR_H12);
`else
            next_x = sum_x;
            next_y = sum_y;
`endif
        end
`ifdef GAME_SPRITE_WRAP_EN
        next_within = 1'b1;
`else
        // A frozen sprite re-evaluates to 0 here, which keeps it frozen until write_xy.
        next_within = on_screen(next_x, next_y);
`endif
    end

    assign hit_now = within_screen &&
                     ({1'b0, pixel_x} >= {1'b0, x}) && ({1'b0, pixel_x} < {1'b0, x} + SPR_W11) &&
                     ({1'b0, pixel_y} >= {1'b0, y}) && ({1'b0, pixel_y} < {1'b0, y} + SPR_H11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x         <= '0;
            pos_y         <= '0;
            vel_x         <= '0;
            vel_y         <= '0;
            div_cnt       <= '0;
            within_screen <= 1'b1;
            sprite_hit    <= 1'b0;
        end else begin
            pos_x         <= next_x;
            pos_y         <= next_y;
            within_screen <= next_within;
            sprite_hit    <= hit_now;
            if (write_dxy) begin
                vel_x <= dx0;
                vel_y <= dy0;
            end
            if (write_xy || !enable_update)
                div_cnt <= '0;
            else if (frame_tick)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_game_sprite_control.sv
// Scoreboard bench for game_sprite_control; follows GAME_SPRITE_WRAP_EN to pick edge or wrap scenarios.
module tb_game_sprite_control;

    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int PW  = 8;
    localparam int PH  = 8;
    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_xy = 1'b0;
    logic       write_dxy = 1'b0;
    logic       enable_update = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] x0 = '0;
    logic [9:0] y0 = '0;
    logic [3:0] dx0 = '0;
    logic [3:0] dy0 = '0;
    logic [9:0] pixel_x = 10'd900;
    logic [9:0] pixel_y = 10'd900;
    logic [9:0] x, y;
    logic       within_screen, sprite_hit;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        int    ex;
        int    ey;
        int    ews;
        int    ehit;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    int mx, my, mdx, mdy, mdiv, mws;

    game_sprite_control #(
        .SCREEN_W  (SW),
        .SCREEN_H  (SH),
        .SPRITE_W  (PW),
        .SPRITE_H  (PH),
        .UPDATE_DIV(DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_xy     (write_xy),
        .write_dxy    (write_dxy),
        .enable_update(enable_update),
        .frame_tick   (frame_tick),
        .x0           (x0),
        .y0           (y0),
        .dx0          (dx0),
        .dy0          (dy0),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .x            (x),
        .y            (y),
        .within_screen(within_screen),
        .sprite_hit   (sprite_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bounds(input int px, input int py);
        return (px >= 0 && px + PW <= SW && py >= 0 && py + PH <= SH) ? 1 : 0;
    endfunction

    function automatic int wrapv(input int v, input int lim);
        return ((v % lim) + lim) % lim;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mdx = 0; mdy = 0; mdiv = 0; mws = 1;
    endtask

    task automatic pop_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 1);
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, "_x"},   32'(x),             e.ex);
        check({e.tag, "_y"},   32'(y),             e.ey);
        check({e.tag, "_ws"},  32'(within_screen), e.ews);
        check({e.tag, "_hit"}, 32'(sprite_hit),    e.ehit);
    endtask

    // Drives one clock cycle of stimulus (called at a negedge), predicts, and checks at the next negedge.
    task automatic cycle(input string tag, input bit wxy, input int x0v, input int y0v,
                         input bit wdxy, input int dxv, input int dyv,
                         input bit en, input bit ft, input int px, input int py);
        exp_t e;
        int   step_now;
        write_xy      = wxy;
        x0            = 10'(x0v);
        y0            = 10'(y0v);
        write_dxy     = wdxy;
        dx0           = 4'(dxv);
        dy0           = 4'(dyv);
        enable_update = en;
        frame_tick    = ft;
        pixel_x       = 10'(px);
        pixel_y       = 10'(py);

        e.tag  = tag;
        e.ehit = (mws != 0 && px >= mx && px < mx + PW && py >= my && py < my + PH) ? 1 : 0;
        step_now = (ft && en && mdiv == DIV - 1 && mws != 0) ? 1 : 0;
        if (wxy) begin
            mx = x0v;
            my = y0v;
`ifdef GAME_SPRITE_WRAP_EN
            mws = 1;
`else
            mws = bounds(mx, my);
`endif
        end else if (step_now != 0) begin
`ifdef GAME_SPRITE_WRAP_EN
            mx  = wrapv(mx + mdx, SW);
            my  = wrapv(my + mdy, SH);
            mws = 1;
`else
            mx  = mx + mdx;
            my  = my + mdy;
            mws = bounds(mx, my);
`endif
        end
        if (wdxy) begin
            mdx = dxv;
            mdy = dyv;
        end
        if (wxy || !en)
            mdiv = 0;
        else if (ft)
            mdiv = (mdiv == DIV - 1) ? 0 : mdiv + 1;
        e.ex  = mx;
        e.ey  = my;
        e.ews = mws;
        exp_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        write_xy   = 1'b0;
        write_dxy  = 1'b0;
        frame_tick = 1'b0;
        pop_compare();
    endtask

    task automatic load(input string tag, input int xv, input int yv, input int dxv, input int dyv,
                        input bit en);
        cycle(tag, 1, xv, yv, 1, dxv, dyv, en, 0, 900, 900);
    endtask

    task automatic tick_pair(input string tag, input bit en);
        cycle(tag, 0, 0, 0, 0, 0, 0, en, 1, 900, 900);
        cycle({tag, "_gap"}, 0, 0, 0, 0, 0, 0, en, 0, 900, 900);
    endtask

    task automatic expect_reset_values(input string tag);
        exp_t e;
        e.tag = tag; e.ex = 0; e.ey = 0; e.ews = 1; e.ehit = 0;
        exp_q.push_back(e);
        pop_compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        expect_reset_values("reset");
        reset = 1'b0;

        // Basic motion: two steps of (+3,-2) over four frame ticks
        load("mv_load", 100, 50, 3, -2, 1);
        for (int i = 0; i < 4; i++) tick_pair("mv_tick", 1);
        check("mv_final_x", 32'(x), 106);
        check("mv_final_y", 32'(y), 46);
        check("mv_final_ws", 32'(within_screen), 1);

        // Raster hit test at the box edge
        load("hit_load", 100, 50, 0, 0, 0);
        cycle("hit_in", 0, 0, 0, 0, 0, 0, 0, 0, 107, 57);
        check("hit_in_direct", 32'(sprite_hit), 1);
        cycle("hit_out", 0, 0, 0, 0, 0, 0, 0, 0, 108, 57);
        check("hit_out_direct", 32'(sprite_hit), 0);
        cycle("hit_above", 0, 0, 0, 0, 0, 0, 0, 0, 100, 49);

        // write_xy beats a coincident step and clears the divider
        load("prio_load", 200, 100, 1, 0, 1);
        tick_pair("prio_tick", 1);
        cycle("prio_wxy", 1, 10, 20, 0, 0, 0, 1, 1, 900, 900);
        check("prio_x", 32'(x), 10);
        tick_pair("prio_after1", 1);
        tick_pair("prio_after2", 1);

        // Frame ticks with updates disabled are ignored
        cycle("dis_tick1", 0, 0, 0, 0, 0, 0, 0, 1, 900, 900);
        cycle("dis_tick2", 0, 0, 0, 0, 0, 0, 0, 1, 900, 900);
        tick_pair("dis_en1", 1);
        tick_pair("dis_en2", 1);

        // Velocity written during a step applies from the next step
        tick_pair("vel_pre", 1);
        cycle("vel_step", 0, 0, 0, 1, -4, 2, 1, 1, 900, 900);
        tick_pair("vel_a", 1);
        tick_pair("vel_b", 1);

`ifdef GAME_SPRITE_WRAP_EN
        load("wrap_load", 638, 50, 3, 0, 1);
        tick_pair("wrap_t1", 1);
        tick_pair("wrap_t2", 1);
        check("wrap_x", 32'(x), 1);
        check("wrap_ws", 32'(within_screen), 1);
`else
        load("edge_load", 630, 50, 3, 0, 1);
        tick_pair("edge_t1", 1);
        tick_pair("edge_t2", 1);
        check("edge_x", 32'(x), 633);
        check("edge_ws", 32'(within_screen), 0);
        for (int i = 0; i < 4; i++) tick_pair("edge_frozen", 1);
        check("edge_frozen_x", 32'(x), 633);
        cycle("edge_hit", 0, 0, 0, 0, 0, 0, 1, 0, 634, 52);
        load("edge_reload", 300, 200, 1, 1, 1);
        tick_pair("edge_r1", 1);
        tick_pair("edge_r2", 1);
`endif

        // Reset asserted while a step is due
        load("rst_load", 100, 50, 2, 1, 1);
        tick_pair("rst_t1", 1);
        enable_update = 1'b1;
        frame_tick    = 1'b1;
        pixel_x       = 10'd500;
        pixel_y       = 10'd400;
        #2;
        reset = 1'b1;
        #1;
        expect_reset_values("rst_async");
        @(negedge clk);
        expect_reset_values("rst_held");
        reset      = 1'b0;
        frame_tick = 1'b0;
        model_reset();
        cycle("rst_vel", 0, 0, 0, 1, 1, 1, 1, 0, 500, 400);
        tick_pair("rst_t_a", 1);
        check("rst_no_early_step_x", 32'(x), 0);
        tick_pair("rst_t_b", 1);
        check("rst_step_x", 32'(x), 1);
        check("rst_step_y", 32'(y), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
